// File: rtl/spi_slave_byte_if_if.sv
// Bus bundle for spi_slave_byte_if: SPI pins plus the core-side rx/tx handshakes.
// Signal suffixes are written from the slave's point of view.
interface spi_slave_byte_if_if #(
    parameter int DATA_W = 8
);
    logic              spi_clk_i;
    logic              spi_mosi_i;
    logic              spi_cs_i;
    logic              spi_miso_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              rx_ready_i;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic              rx_overrun_o;
    logic              tx_underrun_o;
    logic              busy_o;

    modport slave (
        input  spi_clk_i, spi_mosi_i, spi_cs_i, rx_ready_i, tx_data_i, tx_valid_i,
        output spi_miso_o, rx_data_o, rx_valid_o, tx_ready_o,
               rx_overrun_o, tx_underrun_o, busy_o
    );

    modport master (
        output spi_clk_i, spi_mosi_i, spi_cs_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  spi_miso_o, rx_data_o, rx_valid_o, tx_ready_o,
               rx_overrun_o, tx_underrun_o, busy_o
    );
endinterface

// File: rtl/spi_slave_byte_if.sv
// SPI slave that oversamples cs/sclk/mosi in the sys_clk domain, deserialises MOSI
// into DATA_W-bit words (valid/ready) and serialises core words onto MISO, MSB first.
// Build option: define SPI_SLV_RX_FIFO_EN for an RX_DEPTH-entry rx FIFO; otherwise a
// single rx register is used.
module spi_slave_byte_if #(
    parameter int                DATA_W      = 8,
    parameter int                CPOL        = 1,
    parameter int                CPHA        = 1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = {DATA_W{1'b1}},
    parameter int                RX_DEPTH    = 4
) (
    input logic              sys_clk,
    input logic              sys_rst_n,
    spi_slave_byte_if_if.slave bus
);
    localparam int   CNT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic IDLE_SCLK = (CPOL != 0);

    if (SYNC_STAGES < 2 || DATA_W < 2 || RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_param_chk
        $error("spi_slave_byte_if: SYNC_STAGES>=2, DATA_W>=2, RX_DEPTH power of 2 required");
    end

    typedef enum logic {IDLE, ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sclk_prev_q;
    state_e                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-2:0]      rx_shift_q;
    logic [DATA_W-1:0]      tx_shift_q;
    logic                   miso_q, load_pend_q, underrun_q, overrun_q;
    logic [DATA_W-1:0]      hold_q;
    logic                   hold_full_q;

    logic cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic active, start, stop, sample_edge, shift_edge, word_done, load, tx_wr;
    logic [DATA_W-1:0] rx_word_d, tx_word_d;
    logic rx_full, rx_valid_w, rx_pop, rx_accept;

    // Metastability synchronisers and one-cycle-delayed copies for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= {SYNC_STAGES{IDLE_SCLK}};
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= IDLE_SCLK;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi_i};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    assign lead_edge  = IDLE_SCLK ? sclk_fall : sclk_rise;
    assign trail_edge = IDLE_SCLK ? sclk_rise : sclk_fall;
    assign active     = (state_q == ACTIVE) & ~cs_s;
    assign start      = (state_q == IDLE) & cs_prev_q & ~cs_s;
    assign stop       = (state_q == ACTIVE) & cs_s;
    assign sample_edge = active & ((CPHA != 0) ? trail_edge : lead_edge);
    // In CPHA=0 the trailing edge right after a completed word must not shift:
    // the next word's MSB was already driven by the post-word load.
    assign shift_edge = active & ((CPHA != 0) ? lead_edge : (trail_edge & (bit_cnt_q != '0)));
    assign word_done  = sample_edge & (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign rx_word_d  = {rx_shift_q, mosi_s};
    assign load       = start | (load_pend_q & active);
    assign tx_word_d  = hold_full_q ? hold_q : TX_IDLE;
    assign tx_wr      = bus.tx_valid_i & ~hold_full_q;

    // Frame FSM with the serial shift registers, bit counter, MISO and underrun flag
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            load_pend_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            load_pend_q <= word_done;
            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    if (start) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (stop) begin
                        state_q    <= IDLE;
                        miso_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        rx_shift_q <= '0;
                        tx_shift_q <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_word_d[DATA_W-2:0];
                            bit_cnt_q  <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
                        end
                        if (shift_edge) begin
                            miso_q     <= tx_shift_q[DATA_W-1];
                            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (load) begin
                if (CPHA == 0) begin
                    miso_q     <= tx_word_d[DATA_W-1];
                    tx_shift_q <= {tx_word_d[DATA_W-2:0], 1'b0};
                end else begin
                    tx_shift_q <= tx_word_d;
                end
            end
            if (start)             underrun_q <= ~hold_full_q;
            else if (load && !hold_full_q) underrun_q <= 1'b1;
        end
    end

    // tx holding register: filled by the core, emptied by a shift-register load
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (tx_wr) begin
            hold_q      <= bus.tx_data_i;
            hold_full_q <= 1'b1;
        end else if (load && hold_full_q) begin
            hold_full_q <= 1'b0;
        end
    end

`ifdef SPI_SLV_RX_FIFO_EN
    localparam int AW = $clog2(RX_DEPTH);
    logic [DATA_W-1:0] fifo_q [RX_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q;

    assign rx_full    = (cnt_q == (AW+1)'(RX_DEPTH));
    assign rx_valid_w = (cnt_q != '0);
    assign rx_pop     = rx_valid_w & bus.rx_ready_i;
    assign rx_accept  = word_done & (~rx_full | rx_pop);
    assign bus.rx_data_o = fifo_q[rd_ptr_q];

    // rx FIFO: a pop in the same cycle frees a slot for a completing word
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < RX_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (rx_accept) begin
                fifo_q[wr_ptr_q] <= rx_word_d;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (rx_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({rx_accept, rx_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
`else
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    assign rx_full    = rx_valid_q;
    assign rx_valid_w = rx_valid_q;
    assign rx_pop     = rx_valid_q & bus.rx_ready_i;
    assign rx_accept  = word_done & (~rx_full | rx_pop);
    assign bus.rx_data_o = rx_data_q;

    // Single rx register: a pop in the same cycle frees it for a completing word
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_accept) begin
            rx_data_q  <= rx_word_d;
            rx_valid_q <= 1'b1;
        end else if (rx_pop) begin
            rx_valid_q <= 1'b0;
        end
    end
`endif

    // Sticky overrun: set when a completed word finds the buffer full, cleared on cs fall
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                  overrun_q <= 1'b0;
        else if (start)                  overrun_q <= 1'b0;
        else if (word_done && !rx_accept) overrun_q <= 1'b1;
    end

    assign bus.spi_miso_o    = miso_q;
    assign bus.rx_valid_o    = rx_valid_w;
    assign bus.tx_ready_o    = ~hold_full_q;
    assign bus.rx_overrun_o  = overrun_q;
    assign bus.tx_underrun_o = underrun_q;
    assign bus.busy_o        = ~cs_s;
endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Directed bench for spi_slave_byte_if: a mode-3 instance (default) and a mode-0 instance.
module tb_spi_slave_byte_if;
`ifdef SPI_SLV_RX_FIFO_EN
    localparam int NW_OVR = 5;
    localparam int KEEP   = 4;
`else
    localparam int NW_OVR = 2;
    localparam int KEEP   = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_byte_if_if #(.DATA_W(8)) b0 ();
    spi_slave_byte_if_if #(.DATA_W(8)) b1 ();

    spi_slave_byte_if #(.DATA_W(8)) dut0 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b0));
    spi_slave_byte_if #(.DATA_W(8), .CPOL(0), .CPHA(0)) dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b1));

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mst_tx [8];
    logic [7:0] mst_rx [8];
    logic mst_early, mst_busy_mid, mst_unr_mid, mst_ovr_mid;

    typedef struct {
        logic       q;
        logic [7:0] txw;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        logic       exp_unr_mid;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rdd(input int m);
        return (m == 0) ? b0.rx_data_o : b1.rx_data_o;
    endfunction
    function automatic logic rdv(input int m);
        return (m == 0) ? b0.rx_valid_o : b1.rx_valid_o;
    endfunction
    function automatic logic trdy(input int m);
        return (m == 0) ? b0.tx_ready_o : b1.tx_ready_o;
    endfunction
    function automatic logic miso(input int m);
        return (m == 0) ? b0.spi_miso_o : b1.spi_miso_o;
    endfunction

    task automatic set_lines(input int m, input logic cs, input logic sck, input logic mosi);
        if (m == 0) begin
            b0.spi_cs_i = cs; b0.spi_clk_i = sck; b0.spi_mosi_i = mosi;
        end else begin
            b1.spi_cs_i = cs; b1.spi_clk_i = sck; b1.spi_mosi_i = mosi;
        end
    endtask

    task automatic push_tx(input int m, input logic [7:0] d);
        for (int k = 0; k < 100 && !trdy(m); k++) @(negedge clk);
        chk("tx_ready_wait", trdy(m), 1);
        if (m == 0) begin b0.tx_data_i = d; b0.tx_valid_i = 1'b1; end
        else        begin b1.tx_data_i = d; b1.tx_valid_i = 1'b1; end
        @(negedge clk);
        b0.tx_valid_i = 1'b0;
        b1.tx_valid_i = 1'b0;
    endtask

    task automatic pop_rx(input int m);
        if (m == 0) b0.rx_ready_i = 1'b1; else b1.rx_ready_i = 1'b1;
        @(negedge clk);
        b0.rx_ready_i = 1'b0;
        b1.rx_ready_i = 1'b0;
        @(negedge clk);
    endtask

    // SPI master model: half sclk period = 4 sys_clk cycles; all line changes on negedge
    task automatic spi_frame(input int m, input int nw, input int nbits_last);
        logic cpol, cpha, mosi;
        int total;
        cpol = (m == 0);
        cpha = (m == 0);
        total = (nw - 1) * 8 + nbits_last;
        for (int i = 0; i < 8; i++) mst_rx[i] = 8'h00;
        mosi = 1'b0;
        set_lines(m, 1'b1, cpol, 1'b0);
        @(negedge clk);
        if (!cpha) mosi = mst_tx[0][7];
        set_lines(m, 1'b0, cpol, mosi);
        repeat (3) @(negedge clk);
        mst_early = miso(m);
        @(negedge clk);
        for (int b = 0; b < total; b++) begin
            int wi, bi;
            wi = b / 8;
            bi = 7 - (b % 8);
            if (cpha) begin
                mosi = mst_tx[wi][bi];
                set_lines(m, 1'b0, ~cpol, mosi);
                repeat (4) @(negedge clk);
                mst_rx[wi][bi] = miso(m);
                set_lines(m, 1'b0, cpol, mosi);
                repeat (4) @(negedge clk);
            end else begin
                mst_rx[wi][bi] = miso(m);
                set_lines(m, 1'b0, ~cpol, mosi);
                repeat (4) @(negedge clk);
                if (b + 1 < total) mosi = mst_tx[(b + 1) / 8][7 - ((b + 1) % 8)];
                set_lines(m, 1'b0, cpol, mosi);
                repeat (4) @(negedge clk);
            end
            if (b == 3) begin
                mst_busy_mid = (m == 0) ? b0.busy_o : b1.busy_o;
                mst_unr_mid  = (m == 0) ? b0.tx_underrun_o : b1.tx_underrun_o;
                mst_ovr_mid  = (m == 0) ? b0.rx_overrun_o : b1.rx_overrun_o;
            end
        end
        set_lines(m, 1'b1, cpol, mosi);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 1'b0};
        vt[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1};
        vt[2] = '{1'b1, 8'h5A, 8'hC3, 8'hC3, 8'h5A, 1'b0};
        vt[3] = '{1'b0, 8'h00, 8'h96, 8'h96, 8'hFF, 1'b1};

        set_lines(0, 1'b1, 1'b1, 1'b0);
        set_lines(1, 1'b1, 1'b0, 1'b0);
        b0.rx_ready_i = 1'b0; b0.tx_valid_i = 1'b0; b0.tx_data_i = 8'h00;
        b1.rx_ready_i = 1'b0; b1.tx_valid_i = 1'b0; b1.tx_data_i = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // reset state
        chk("rst_miso", b0.spi_miso_o, 0);
        chk("rst_rx_valid", b0.rx_valid_o, 0);
        chk("rst_rx_data", b0.rx_data_o, 0);
        chk("rst_tx_ready", b0.tx_ready_o, 1);
        chk("rst_overrun", b0.rx_overrun_o, 0);
        chk("rst_underrun", b0.tx_underrun_o, 0);
        chk("rst_busy", b0.busy_o, 0);
        chk("rst_miso_m0", b1.spi_miso_o, 0);

        // single-word mode-3 frames from the vector table
        for (int r = 0; r < 4; r++) begin
            if (vt[r].q) begin
                push_tx(0, vt[r].txw);
                chk("vec_tx_ready_held", b0.tx_ready_o, 0);
            end
            mst_tx[0] = vt[r].mosi;
            spi_frame(0, 1, 8);
            chk("vec_miso_word", mst_rx[0], vt[r].exp_miso);
            chk("vec_busy_mid", mst_busy_mid, 1);
            chk("vec_underrun_mid", mst_unr_mid, vt[r].exp_unr_mid);
            chk("vec_rx_valid", b0.rx_valid_o, 1);
            chk("vec_rx_data", b0.rx_data_o, vt[r].exp_rx);
            chk("vec_tx_ready", b0.tx_ready_o, 1);
            chk("vec_underrun_end", b0.tx_underrun_o, 1);
            chk("vec_busy_end", b0.busy_o, 0);
            pop_rx(0);
            chk("vec_rx_popped", b0.rx_valid_o, 0);
        end

        // overrun: core never ready while NW_OVR words arrive
        for (int k = 0; k < 8; k++) mst_tx[k] = 8'(k + 1);
        spi_frame(0, NW_OVR, 8);
        chk("ovr_flag", b0.rx_overrun_o, 1);
        for (int k = 0; k < KEEP; k++) begin
            chk("ovr_keep_valid", b0.rx_valid_o, 1);
            chk("ovr_keep_data", b0.rx_data_o, k + 1);
            pop_rx(0);
        end
        chk("ovr_drained", b0.rx_valid_o, 0);

        // cs raised after 5 bits, then a clean frame
        mst_tx[0] = 8'hFF;
        spi_frame(0, 1, 5);
        chk("part_no_valid", b0.rx_valid_o, 0);
        chk("part_ovr_cleared", mst_ovr_mid, 0);
        mst_tx[0] = 8'h81;
        spi_frame(0, 1, 8);
        chk("part_next_valid", b0.rx_valid_o, 1);
        chk("part_next_data", b0.rx_data_o, 8'h81);
        pop_rx(0);

        // async reset mid-word with an unread rx word and a held tx word
        mst_tx[0] = 8'h11;
        spi_frame(0, 1, 8);
        set_lines(0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        push_tx(0, 8'hEE);
        for (int b = 0; b < 3; b++) begin
            set_lines(0, 1'b0, 1'b0, 1'b1);
            repeat (4) @(negedge clk);
            set_lines(0, 1'b0, 1'b1, 1'b1);
            repeat (4) @(negedge clk);
        end
        chk("pre_rst_valid", b0.rx_valid_o, 1);
        chk("pre_rst_tx_ready", b0.tx_ready_o, 0);
        chk("pre_rst_busy", b0.busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_miso", b0.spi_miso_o, 0);
        chk("arst_rx_valid", b0.rx_valid_o, 0);
        chk("arst_rx_data", b0.rx_data_o, 0);
        chk("arst_tx_ready", b0.tx_ready_o, 1);
        chk("arst_overrun", b0.rx_overrun_o, 0);
        chk("arst_underrun", b0.tx_underrun_o, 0);
        chk("arst_busy", b0.busy_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_lines(0, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        mst_tx[0] = 8'h5A;
        spi_frame(0, 1, 8);
        chk("post_rst_valid", b0.rx_valid_o, 1);
        chk("post_rst_data", b0.rx_data_o, 8'h5A);
        chk("post_rst_miso", mst_rx[0], 8'hFF);
        pop_rx(0);

        // mode-0 instance: tx C3 queued, master sends 96
        push_tx(1, 8'hC3);
        mst_tx[0] = 8'h96;
        spi_frame(1, 1, 8);
        chk("m0_miso_early", mst_early, 1);
        chk("m0_miso_word", mst_rx[0], 8'hC3);
        chk("m0_rx_valid", rdv(1), 1);
        chk("m0_rx_data", rdd(1), 8'h96);
        chk("m0_tx_ready", trdy(1), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
